// File: rtl/wrr_arbiter_n.sv
// N-way weighted round-robin arbiter with strict-priority mode.
// Grants are combinational; owner and remaining quantum are the only state.
module wrr_arbiter_n #(
  parameter int N    = 4,
  parameter int WT_W = 5,
  localparam int IDX_W = $clog2(N)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mode_strict,
  input  logic [N-1:0]      req,
  input  logic [N*WT_W-1:0] wt,
  input  logic              gnt_busy,
  output logic [N-1:0]      gnt,
  output logic [IDX_W-1:0]  gnt_idx,
  output logic              gnt_vld,
  output logic              gnt_last
);

  logic [IDX_W-1:0] r_owner;
  logic             r_owner_vld;
  logic [WT_W-1:0]  r_wt_left;

  logic [N-1:0]     w_req_eff;
  logic             w_any;
  logic             w_hold;
  logic             w_fire;
  logic             w_found;
  logic [IDX_W-1:0] w_start;
  logic [IDX_W-1:0] w_sel;
  logic [IDX_W-1:0] w_idx;
  logic [WT_W-1:0]  w_wt_sel;
  logic [WT_W-1:0]  w_left_nxt;

  // A zero weight disables a requester in WRR; strict mode ignores weights.
  always_comb begin
    w_req_eff = '0;
    for (int i = 0; i < N; i++) begin
      w_req_eff[i] = req[i] & (mode_strict | (wt[i*WT_W +: WT_W] != '0));
    end
  end

  assign w_any  = |w_req_eff;
  assign w_hold = !mode_strict && r_owner_vld && w_req_eff[r_owner] &&
                  (r_wt_left != '0);

  // Strict mode searches from 0, which makes the cyclic search a priority encoder.
  always_comb begin
    w_start = '0;
    if (r_owner_vld && !mode_strict) begin
      w_start = (r_owner == IDX_W'(N-1)) ? '0 : r_owner + 1'b1;
    end
  end

  always_comb begin
    int j;
    w_found = 1'b0;
    w_sel   = '0;
    j       = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(w_start) + k;
      if (j >= N) j = j - N;
      if (!w_found && w_req_eff[j]) begin
        w_found = 1'b1;
        w_sel   = IDX_W'(j);
      end
    end
  end

  assign w_idx    = w_hold ? r_owner : w_sel;
  assign w_wt_sel = wt[w_idx*WT_W +: WT_W];

  always_comb begin
    w_left_nxt = '0;
    if (mode_strict) begin
      w_left_nxt = '0;
    end else if (w_hold) begin
      w_left_nxt = r_wt_left - 1'b1;
    end else if (w_wt_sel != '0) begin
      w_left_nxt = w_wt_sel - 1'b1;
    end
  end

  // Handshake: gnt_vld is the valid, !gnt_busy is the ready; a grant is
  // presented and state advances only in a cycle where both hold.
  assign w_fire   = !gnt_busy && w_any;
  assign gnt      = w_fire ? ({{(N-1){1'b0}}, 1'b1} << w_idx) : '0;
  assign gnt_idx  = w_fire ? w_idx : '0;
  assign gnt_vld  = w_fire;
  assign gnt_last = w_fire && (w_left_nxt == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_owner     <= '0;
      r_owner_vld <= 1'b0;
      r_wt_left   <= '0;
    end else if (w_fire) begin
      r_owner     <= w_idx;
      r_owner_vld <= 1'b1;
      r_wt_left   <= w_left_nxt;
    end
  end

endmodule

// File: tb/tb_wrr_arbiter_n.sv
// Bench for wrr_arbiter_n: directed scenarios with constant expectations plus
// a randomised run, all outputs scored against a reference model via exp_q.
module tb_wrr_arbiter_n;
  localparam int N     = 4;
  localparam int WT_W  = 5;
  localparam int IDX_W = 2;
  localparam int W     = N + IDX_W + 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              mode_strict;
  logic [N-1:0]      req;
  logic [N*WT_W-1:0] wt;
  logic              gnt_busy;
  logic [N-1:0]      gnt;
  logic [IDX_W-1:0]  gnt_idx;
  logic              gnt_vld;
  logic              gnt_last;

  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  logic [IDX_W-1:0] m_owner;
  logic             m_vld;
  logic [WT_W-1:0]  m_left;
  logic             m_upd;
  logic [IDX_W-1:0] m_nowner;
  logic [WT_W-1:0]  m_nleft;

  // last observed outputs
  logic [N-1:0]     o_gnt;
  logic [IDX_W-1:0] o_idx;
  logic             o_last;

  wrr_arbiter_n #(.N(N), .WT_W(WT_W)) dut (
    .clk(clk), .reset(reset), .mode_strict(mode_strict), .req(req), .wt(wt),
    .gnt_busy(gnt_busy), .gnt(gnt), .gnt_idx(gnt_idx), .gnt_vld(gnt_vld),
    .gnt_last(gnt_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [WT_W-1:0] wof(input int i);
    return wt[i*WT_W +: WT_W];
  endfunction

  task automatic set_wt(input int i, input int v);
    wt[i*WT_W +: WT_W] = WT_W'(v);
  endtask

  task automatic model_predict();
    logic [N-1:0]    eff;
    logic [N-1:0]    oh;
    logic [WT_W-1:0] left;
    int s;
    eff = '0; oh = '0; left = '0; s = -1;
    for (int i = 0; i < N; i++) eff[i] = mode_strict ? req[i] : (req[i] && wof(i) != 0);
    m_upd = !gnt_busy && (eff != 0);
    if (mode_strict) begin
      for (int i = N-1; i >= 0; i--) if (eff[i]) s = i;
      left = '0;
    end else if (m_vld && eff[m_owner] && m_left != 0) begin
      s = int'(m_owner);
      left = m_left - 1;
    end else begin
      for (int k = N; k >= 1; k--) begin
        int c;
        c = m_vld ? (int'(m_owner) + k) % N : k - 1;
        if (eff[c]) s = c;
      end
      if (s >= 0) left = wof(s) - 1;
    end
    if (m_upd) begin
      oh[s] = 1'b1;
      exp_q.push_back({oh, IDX_W'(s), 1'b1, left == 0});
      m_nowner = IDX_W'(s);
      m_nleft  = left;
    end else begin
      exp_q.push_back('0);
    end
  endtask

  // Called just after a rising edge with inputs already applied.
  task automatic step(input logic rst);
    reset = rst;
    if (!rst) model_predict();
    @(negedge clk);
    o_gnt = gnt; o_idx = gnt_idx; o_last = gnt_last;
    if (!rst) begin
      if (exp_q.size() == 0) check("sb_empty", 1, 0);
      else check("sb", {gnt, gnt_idx, gnt_vld, gnt_last}, exp_q.pop_front());
    end
    @(posedge clk);
    if (rst) begin
      m_owner = '0; m_vld = 1'b0; m_left = '0;
    end else if (m_upd) begin
      m_owner = m_nowner; m_vld = 1'b1; m_left = m_nleft;
    end
    #1;
  endtask

  int t1_idx[10]  = '{0, 0, 0, 1, 1, 0, 0, 0, 1, 1};
  int t1_last[10] = '{0, 0, 1, 0, 1, 0, 0, 1, 0, 1};

  initial begin
    reset = 1'b1; mode_strict = 1'b0; req = '0; wt = '0; gnt_busy = 1'b0;
    m_owner = '0; m_vld = 1'b0; m_left = '0; m_upd = 1'b0;
    @(posedge clk); #1;
    step(1'b1);
    step(1'b1);
    step(1'b0);
    check("rst_gnt", o_gnt, 0);

    // basic weighted rotation, weights 3 and 2
    set_wt(0, 3); set_wt(1, 2); req = 4'b0011;
    for (int c = 0; c < 10; c++) begin
      step(1'b0);
      check("t1_idx", o_idx, t1_idx[c]);
      check("t1_last", o_last, t1_last[c]);
    end

    // zero weight disables in WRR; strict ignores weight
    set_wt(2, 0); req = 4'b0100;
    for (int c = 0; c < 3; c++) begin
      step(1'b0);
      check("t2_wrr_gnt", o_gnt, 0);
    end
    mode_strict = 1'b1;
    step(1'b0);
    check("t2_strict_gnt", o_gnt, 4'b0100);

    // busy freezes a quantum with one beat left
    mode_strict = 1'b0; req = 4'b0001;
    step(1'b0); check("t3_a", o_gnt, 4'b0001);
    step(1'b0); check("t3_b_last", o_last, 0);
    gnt_busy = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step(1'b0);
      check("t3_busy_gnt", o_gnt, 0);
    end
    gnt_busy = 1'b0;
    step(1'b0);
    check("t3_gnt", o_gnt, 4'b0001);
    check("t3_last", o_last, 1);
    step(1'b0);
    check("t3_rewin_last", o_last, 0);

    // owner 3 drops mid-quantum: wrap to 0 same cycle
    set_wt(3, 5); req = 4'b1000;
    step(1'b0); check("t4_own3", o_idx, 3);
    req = 4'b0011;
    step(1'b0); check("t4_wrap", o_idx, 0);

    // strict priority starves index 3
    mode_strict = 1'b1; req = 4'b1010;
    for (int i = 0; i < N; i++) set_wt(i, 7);
    for (int c = 0; c < 4; c++) begin
      step(1'b0);
      check("t5_gnt", o_gnt, 4'b0010);
    end

    // reset mid-quantum discards owner 2
    mode_strict = 1'b0; set_wt(2, 5); req = 4'b0100;
    step(1'b0); check("t6_own2", o_idx, 2);
    req = 4'b1111;
    step(1'b1);
    for (int c = 0; c < 7; c++) begin
      step(1'b0);
      check("t6_idx", o_idx, 0);
      check("t6_last", o_last, (c == 6) ? 1 : 0);
    end

    // randomised run against the model
    for (int c = 0; c < 400; c++) begin
      req = N'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) set_wt($urandom_range(0, N-1), $urandom_range(0, 7));
      mode_strict = ($urandom_range(0, 9) == 0);
      gnt_busy = ($urandom_range(0, 4) == 0);
      step($urandom_range(0, 63) == 0);
    end

    if (exp_q.size() != 0) check("sb_leftover", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
